// File: rtl/lc_ctrl_pkg.sv
// Shared types and helpers for the life-cycle transition controller:
// decoded life-cycle state encoding, controller FSM states, error codes
// and the legal-transition rule.
package lc_ctrl_pkg;

    typedef enum logic [4:0] {
        DecLcStRaw           = 5'd0,
        DecLcStTestUnlocked0 = 5'd1,
        DecLcStTestLocked0   = 5'd2,
        DecLcStTestUnlocked1 = 5'd3,
        DecLcStTestLocked1   = 5'd4,
        DecLcStTestUnlocked2 = 5'd5,
        DecLcStTestLocked2   = 5'd6,
        DecLcStTestUnlocked3 = 5'd7,
        DecLcStTestLocked3   = 5'd8,
        DecLcStTestUnlocked4 = 5'd9,
        DecLcStTestLocked4   = 5'd10,
        DecLcStTestUnlocked5 = 5'd11,
        DecLcStTestLocked5   = 5'd12,
        DecLcStTestUnlocked6 = 5'd13,
        DecLcStTestLocked6   = 5'd14,
        DecLcStTestUnlocked7 = 5'd15,
        DecLcStDev           = 5'd16,
        DecLcStProd          = 5'd17,
        DecLcStProdEnd       = 5'd18,
        DecLcStRma           = 5'd19,
        DecLcStScrap         = 5'd20,
        DecLcStPostTrans     = 5'd21,
        DecLcStEscalate      = 5'd22,
        DecLcStInvalid       = 5'd23
    } dec_lc_state_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCheck     = 3'd1,
        StTokenWait = 3'd2,
        StProgram   = 3'd3,
        StDone      = 3'd4,
        StError     = 3'd5,
        StEscalated = 3'd6
    } lc_fsm_e;

    typedef enum logic [1:0] {
        ErrTimeout  = 2'd0,
        ErrIllegal  = 2'd1,
        ErrTokenBad = 2'd2,
        ErrCntSat   = 2'd3
    } err_code_e;

    // A transition must strictly climb the encoding, never leave or pass
    // Scrap, and never land on Raw.
    function automatic logic lc_trans_legal(input dec_lc_state_e cur,
                                            input dec_lc_state_e tgt);
        return (cur <= DecLcStScrap) && (tgt <= DecLcStScrap) &&
               (tgt > cur) && (tgt != DecLcStRaw);
    endfunction

endpackage

// File: rtl/lc_trans_timer.sv
// Loadable down-counter with a zero flag. Load has priority over decrement
// and the count never wraps below zero.
module lc_trans_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_r;

    // Count register: load, else decrement while non-zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (load_i) begin
            cnt_r <= load_val_i;
        end else if (dec_i && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end
    end

    assign zero_o = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/lc_transition_ctrl.sv
// Life-cycle transition controller: accepts one request at a time, checks
// legality, waits for the token verdict, runs a fixed programming phase and
// commits the new state. Escalation forces a terminal Escalate state.
// Optional build macro LC_TRANS_CNT_EN adds a saturating transition counter
// (trans_cnt_o) that blocks further transitions once MAX_TRANS is reached.
module lc_transition_ctrl
    import lc_ctrl_pkg::*;
#(
    parameter int PROG_CYCLES   = 4,
    parameter int TOKEN_TIMEOUT = 16,
    parameter int MAX_TRANS     = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [4:0] req_target_i,
    input  logic       token_valid_i,
    input  logic       token_ok_i,
    input  logic       esc_i,
    output logic [4:0] lc_state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o
`ifdef LC_TRANS_CNT_EN
    ,
    output logic [$clog2(MAX_TRANS+1)-1:0] trans_cnt_o
`endif
);

    localparam int TOK_W  = $clog2(TOKEN_TIMEOUT + 1);
    localparam int PROG_W = $clog2(PROG_CYCLES + 1);

    lc_fsm_e       state_r;
    dec_lc_state_e lc_state_r;
    dec_lc_state_e target_r;
    logic          req_ready_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    err_code_e     err_code_r;

    logic tok_load_s, tok_dec_s, tok_zero_s;
    logic prog_load_s, prog_dec_s, prog_zero_s;
    logic cnt_sat_s;

    // The token timer is armed in CHECK so it holds TOKEN_TIMEOUT-1 on the
    // first TOKEN_WAIT cycle; zero then marks the last waiting cycle.
    assign tok_load_s  = (state_r == StCheck);
    assign tok_dec_s   = (state_r == StTokenWait);
    // The programming counter is re-armed every TOKEN_WAIT cycle so it holds
    // PROG_CYCLES-1 on the first PROGRAM cycle.
    assign prog_load_s = (state_r == StTokenWait);
    assign prog_dec_s  = (state_r == StProgram);

    lc_trans_timer #(.W(TOK_W)) u_tok_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tok_load_s),
        .load_val_i (TOK_W'(TOKEN_TIMEOUT - 1)),
        .dec_i      (tok_dec_s),
        .zero_o     (tok_zero_s)
    );

    lc_trans_timer #(.W(PROG_W)) u_prog_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (prog_load_s),
        .load_val_i (PROG_W'(PROG_CYCLES - 1)),
        .dec_i      (prog_dec_s),
        .zero_o     (prog_zero_s)
    );

`ifdef LC_TRANS_CNT_EN
    localparam int CNT_W = $clog2(MAX_TRANS + 1);
    logic [CNT_W-1:0] trans_cnt_r;

    // Saturating count of committed transitions; an escalated commit is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trans_cnt_r <= {CNT_W{1'b0}};
        end else if (!esc_i && (state_r == StDone) &&
                     (trans_cnt_r != CNT_W'(MAX_TRANS))) begin
            trans_cnt_r <= trans_cnt_r + CNT_W'(1);
        end
    end

    assign cnt_sat_s   = (trans_cnt_r == CNT_W'(MAX_TRANS));
    assign trans_cnt_o = trans_cnt_r;
`else
    assign cnt_sat_s = 1'b0;
`endif

    // Main sequencer: state, committed life-cycle state and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= StIdle;
            lc_state_r  <= DecLcStRaw;
            target_r    <= DecLcStRaw;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ErrTimeout;
        end else if (esc_i) begin
            state_r     <= StEscalated;
            lc_state_r  <= DecLcStEscalate;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ErrTimeout;
        end else begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ErrTimeout;
            case (state_r)
                StIdle: begin
                    if (req_valid_i) begin
                        state_r     <= StCheck;
                        target_r    <= dec_lc_state_e'(req_target_i);
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                StCheck: begin
                    if (cnt_sat_s) begin
                        state_r    <= StError;
                        err_r      <= 1'b1;
                        err_code_r <= ErrCntSat;
                        busy_r     <= 1'b0;
                    end else if (lc_trans_legal(lc_state_r, target_r)) begin
                        state_r <= StTokenWait;
                    end else begin
                        state_r    <= StError;
                        err_r      <= 1'b1;
                        err_code_r <= ErrIllegal;
                        busy_r     <= 1'b0;
                    end
                end
                StTokenWait: begin
                    if (token_valid_i && token_ok_i) begin
                        state_r <= StProgram;
                    end else if (token_valid_i) begin
                        state_r    <= StError;
                        err_r      <= 1'b1;
                        err_code_r <= ErrTokenBad;
                        busy_r     <= 1'b0;
                    end else if (tok_zero_s) begin
                        state_r    <= StError;
                        err_r      <= 1'b1;
                        err_code_r <= ErrTimeout;
                        busy_r     <= 1'b0;
                    end
                end
                StProgram: begin
                    if (prog_zero_s) begin
                        state_r <= StDone;
                        done_r  <= 1'b1;
                    end
                end
                StDone: begin
                    lc_state_r  <= target_r;
                    state_r     <= StIdle;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                StError: begin
                    state_r     <= StIdle;
                    req_ready_r <= 1'b1;
                end
                StEscalated: begin
                    state_r     <= StEscalated;
                    req_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= StIdle;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_r;
    assign lc_state_o  = lc_state_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign err_code_o  = err_code_r;

endmodule
